// File: rtl/crc_check_serial_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | crc_check_serial_if : bit-in / result-out handshake bundle of the checker
// | Revision 1.0
// +----------------------------------------------------------------------------
interface crc_check_serial_if #(
  parameter int N = 16,
  parameter int R = 7
);
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [R-2:0] out_syndrome;
  logic         out_err;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_data, out_syndrome, out_err
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_data, out_syndrome, out_err
  );
endinterface
`default_nettype wire

// File: rtl/crc_check_serial.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | crc_check_serial : bit-serial CRC long-division checker, MSB first.
// | Optional frame/error statistics counters: CRC_CHECK_STATS_EN
// | Revision 1.0
// +----------------------------------------------------------------------------
module crc_check_serial #(
  parameter int           N   = 16,
  parameter int           R   = 7,
  parameter logic [R-1:0] DIV = 7'b1111011
) (
  input  wire logic         clk,
  input  wire logic         rst,
  crc_check_serial_if.slave bus,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
);

  localparam int               CNT_W  = $clog2(N + R);
  localparam logic [CNT_W-1:0] C_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N + R - 2);

  typedef enum logic [0:0] {
    S_SHIFT = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [R-2:0]       r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [N-1:0]       r_data;
  logic [N-1:0]       r_out_data;
  logic [R-2:0]       r_out_syn;
  logic               r_out_err;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_done_hs;
  logic               w_last;
  logic [R-1:0]       w_t;
  logic [R-1:0]       w_t_red;
  logic [R-2:0]       w_rem_next;

  // One long-division step: bring in the next bit, subtract g(x) if the top is set.
  assign w_t        = {r_rem, bus.in_bit};
  assign w_t_red    = w_t[R-1] ? (w_t ^ DIV) : w_t;
  assign w_rem_next = w_t_red[R-2:0];
  assign w_last     = (r_cnt == C_LAST);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_done_hs  = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_SHIFT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_SHIFT: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = S_SHIFT;
        end
      end
      default: begin
        w_state_next = S_SHIFT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem      <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_out_data <= '0;
      r_out_syn  <= '0;
      r_out_err  <= 1'b0;
    end else if (w_accept) begin
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt < C_N) begin
        r_data <= {r_data[N-2:0], bus.in_bit};
      end
      // The data word is complete long before the last (CRC) bit arrives.
      if (w_last) begin
        r_out_data <= r_data;
        r_out_syn  <= w_rem_next;
        r_out_err  <= |w_rem_next;
      end
    end else if (w_done_hs) begin
      r_rem <= '0;
      r_cnt <= '0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_syndrome = r_out_syn;
  assign bus.out_err      = r_out_err;

`ifdef CRC_CHECK_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_done_hs) begin
      if (r_frame_cnt != 16'hFFFF) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (r_out_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`else
  assign frame_cnt = 16'd0;
  assign err_cnt   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc_check_serial.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_crc_check_serial : scoreboard bench for the serial CRC checker
// | Revision 1.0
// +----------------------------------------------------------------------------
module tb_crc_check_serial;
  localparam int           N   = 16;
  localparam int           R   = 7;
  localparam int           W   = N + R - 1;
  localparam logic [R-1:0] DIV = 7'b1111011;

  typedef struct packed {
    logic [N-1:0] data;
    logic [R-2:0] syn;
    logic         err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  crc_check_serial_if #(.N(N), .R(R)) bus ();

  crc_check_serial #(.N(N), .R(R), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  res_t sb[$];
  int   n_checks   = 0;
  int   n_fails    = 0;
  int   mdl_frames = 0;
  int   mdl_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference remainder by whole-word polynomial division.
  function automatic logic [R-2:0] mdl_syn(input logic [W-1:0] cw);
    logic [W-1:0] v;
    v = cw;
    for (int i = W - 1; i >= R - 1; i--) begin
      if (v[i]) v = v ^ (W'(DIV) << (i - (R - 1)));
    end
    return v[R-2:0];
  endfunction

  task automatic expect_res(input logic [N-1:0] d, input logic [R-2:0] s);
    res_t r;
    r.data = d;
    r.syn  = s;
    r.err  = (s != '0);
    sb.push_back(r);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    int   t;
    logic w;
    t = 0;
    w = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    while (!w) begin
      @(negedge clk);
      w = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
      if (t > 200) begin
        check_eq("in_ready_timeout", 0, 1);
        w = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [W-1:0] cw, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
      drive_bit(cw[i]);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic check_stats(input string tag);
    int ef;
    int ee;
`ifdef CRC_CHECK_STATS_EN
    ef = mdl_frames;
    ee = mdl_errs;
`else
    ef = 0;
    ee = 0;
`endif
    check_eq({tag, "_frame_cnt"}, frame_cnt, ef);
    check_eq({tag, "_err_cnt"}, err_cnt, ee);
  endtask

  // Output monitor: handshake pops the scoreboard; stalls must hold outputs.
  res_t held;
  res_t exp_r;
  bit   hold_prev = 1'b0;
  bit   hs_prev   = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("in_ready_vs_valid", bus.in_ready, !bus.out_valid);
      if (hs_prev) check_eq("valid_pulse", bus.out_valid, 0);
      if (hold_prev) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_data", bus.out_data, held.data);
        check_eq("hold_syn", bus.out_syndrome, held.syn);
        check_eq("hold_err", bus.out_err, held.err);
      end
      hs_prev   = bus.out_valid && bus.out_ready;
      hold_prev = bus.out_valid && !bus.out_ready;
      if (hold_prev) held = {bus.out_data, bus.out_syndrome, bus.out_err};
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_valid", 1, 0);
        end else begin
          exp_r = sb.pop_front();
          check_eq("out_data", bus.out_data, exp_r.data);
          check_eq("out_syndrome", bus.out_syndrome, exp_r.syn);
          check_eq("out_err", bus.out_err, exp_r.err);
          mdl_frames++;
          if (exp_r.err) mdl_errs++;
        end
      end
    end else begin
      hs_prev   = 1'b0;
      hold_prev = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] d;
    logic [W-1:0] cw;
    int           t;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_out_syn", bus.out_syndrome, 0);
    check_eq("rst_out_err", bus.out_err, 0);
    check_stats("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean frame, single-bit errors, burst error.
    expect_res(16'h0001, 6'b000000);
    send(22'h00007B, 1'b0);
    wait_drain();
    expect_res(16'h0001, 6'b000001);
    send(22'h00007A, 1'b0);
    expect_res(16'h0000, 6'b111011);
    send(22'h00003B, 1'b0);
    expect_res(16'h0001, 6'b000011);
    send(22'h000078, 1'b0);
    wait_drain();
    check_stats("four_frames");

    // Backpressure with input gaps, then a back-to-back zero frame.
    bus.out_ready = 1'b0;
    expect_res(16'h0001, 6'b000000);
    send(22'h00007B, 1'b1);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("bp_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'($urandom);
      @(negedge clk);
      check_eq("bp_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    expect_res(16'h0000, 6'b000000);
    send(22'h000000, 1'b1);
    wait_drain();

    // Random codewords, some with a single flipped bit.
    for (int k = 0; k < 4; k++) begin
      d  = N'($urandom);
      cw = {d, mdl_syn({d, 6'b000000})};
      if (k[0]) cw[$urandom_range(0, W - 1)] ^= 1'b1;
      expect_res(cw[W-1:R-1], mdl_syn(cw));
      send(cw, 1'b1);
    end
    wait_drain();
    check_stats("random");

    // Abort a frame after 11 bits; only the following clean frame may emerge.
    cw = 22'h00007B;
    for (int i = W - 1; i >= W - 11; i--) drive_bit(cw[i]);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    mdl_frames = 0;
    mdl_errs   = 0;
    check_eq("abort_out_valid", bus.out_valid, 0);
    check_eq("abort_in_ready", bus.in_ready, 1);
    check_eq("abort_out_data", bus.out_data, 0);
    check_eq("abort_out_syn", bus.out_syndrome, 0);
    check_eq("abort_out_err", bus.out_err, 0);
    check_stats("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_res(16'h0001, 6'b000000);
    send(22'h00007B, 1'b0);
    wait_drain();
    idle(3);
    check_stats("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/crc_check_serial.md
# crc_check_serial

Bit-serial CRC checker sitting directly downstream of the combinational CRC encoder and the error-injection channel. It accepts one codeword bit per handshake, MSB first, and performs polynomial long division with a shift register. After the last of the N+R-1 codeword bits it presents the recovered N-bit data word, the R-1-bit syndrome and an error flag on a registered valid/ready output port. Generator polynomial and widths match the encoder, so any codeword produced by the encoder checks clean.

## Interface
- `N`, 16: data bits per codeword.
- `R`, 7: divisor length in bits; the CRC field is R-1 bits.
- `DIV`, 7'b1111011: generator g(x) = x^6+x^5+x^4+x^3+x+1, MSB = x^(R-1).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_bit` is valid.
- `in_bit`  in  1  codeword bit; codeword bit N+R-2 first, bit 0 last.
- `in_ready`  out  1  block accepts a bit this cycle.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  N  first N received bits (codeword[N+R-2:R-1]).
- `out_syndrome`  out  R-1  final remainder.
- `out_err`  out  1  `out_syndrome` != 0.
- `frame_cnt`  out  16  frames delivered (see Configuration).
- `err_cnt`  out  16  frames delivered with `out_err`=1 (see Configuration).

## Operation
- Two states: SHIFT and DONE. Reset enters SHIFT.
- SHIFT: `in_ready`=1, `out_valid`=0. On each accepted bit b (`in_valid && in_ready`):
  - t = {rem, b} (R bits); if t[R-1], t = t ^ DIV; rem <= t[R-2:0].
  - While bit count < N, also shift b into the data register LSB.
  - Increment bit count.
- Acceptance of bit count N+R-2 (the last bit): next edge loads `out_data`, `out_syndrome` = new rem, `out_err` = |new rem; state <= DONE.
- DONE: `in_ready`=0, `out_valid`=1; outputs are held stable.
  - On `out_valid && out_ready`: state <= SHIFT, rem <= 0, bit count <= 0.
- `in_valid` low in SHIFT: all state holds and bits are not consumed. Gaps of any length are legal.
- `in_bit` is ignored when `in_valid`=0 or `in_ready`=0.
- Any odd-weight error and any burst of length ≤ R-1 gives a nonzero syndrome.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_syndrome`=0, `out_err`=0, `frame_cnt`=0, `err_cnt`=0. Internal rem and bit count are also 0.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from input to output.
- Latency: `out_valid` rises on the edge that accepts the final bit. Minimum frame period is N+R-1 bit cycles plus 1 result-handshake cycle (23 cycles by default).
- Backpressure: `out_ready`=0 holds DONE indefinitely, and no input bit is consumed during that time.
- Reset asserted mid-frame or in DONE aborts the frame immediately. Outputs return to their reset values and no partial result is emitted.

## Configuration
- `CRC_CHECK_STATS_EN` defined:
  - `frame_cnt` increments on each `out_valid && out_ready`.
  - `err_cnt` increments on the same handshake when `out_err`=1.
  - Both counters saturate at 16'hFFFF and clear only on `rst`.
- `CRC_CHECK_STATS_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Clean frame: shift 22'h00007B (data 16'h0001, CRC 6'b111011) with `out_ready`=1 → `out_data`=16'h0001, `out_syndrome`=0, `out_err`=0, `out_valid` high for one cycle.
- Single-bit error: shift 22'h00007A → `out_syndrome`=6'b000001, `out_err`=1. Also shift 22'h00003B (data bit flipped) → `out_syndrome`=6'b111011, `out_data`=16'h0000.
- Burst error: shift 22'h000078 → `out_syndrome`=6'b000011, `out_err`=1.
- Handshake:
  - Random `in_valid` gaps plus `out_ready` held low for 10 cycles after the clean frame.
  - Required: `in_ready`=0 and outputs stable throughout; a back-to-back second frame 22'h000000 yields syndrome 0.
- Reset after 11 bits of a frame, then a full clean frame → no spurious `out_valid`; the result matches the clean frame only.
- With `CRC_CHECK_STATS_EN`: scenarios 1–3 in sequence → `frame_cnt`=4, `err_cnt`=3. Without the macro → both read 0.
